// File: rtl/acc_requant_pipe_pkg.sv
// Fixed-point format shared between the requantizer and the tanh activation.
// Holds the output format, its saturation bounds and the shift derivation.
package acc_requant_pipe_pkg;

   localparam int W_OUT = 12;
   localparam int OUT_I = 4;
   localparam int OUT_F = W_OUT - OUT_I;

   localparam logic [W_OUT-1:0] SAT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
   localparam logic [W_OUT-1:0] SAT_MIN = {1'b1, {(W_OUT-1){1'b0}}};

   function automatic int calc_shift(int acc_f, int w_out, int out_i);
      return acc_f - (w_out - out_i);
   endfunction

endpackage

// File: rtl/acc_requant_pipe_round_sat.sv
// Combinational datapath: round-half-up of the accumulator (pre-register)
// and two's-complement clip of the registered rounded value (post-register).
module requant_round_sat
   import acc_requant_pipe_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int ACC_F = 16,
   parameter int W_OUT = acc_requant_pipe_pkg::W_OUT,
   parameter int OUT_I = acc_requant_pipe_pkg::OUT_I,
   localparam int SHIFT = calc_shift(ACC_F, W_OUT, OUT_I),
   localparam int R_W = ACC_W + 1 - SHIFT
) (
   input  logic [ACC_W-1:0] acc,
   output logic [R_W-1:0]   r,
   input  logic [R_W-1:0]   r_q,
   output logic [W_OUT-1:0] sat_data,
   output logic             sat
);

   localparam logic [W_OUT-1:0] MAXV = {1'b0, {(W_OUT-1){1'b1}}};
   localparam logic [W_OUT-1:0] MINV = {1'b1, {(W_OUT-1){1'b0}}};

   if (SHIFT < 0 || OUT_I < 1) begin : g_bad_cfg
      $error("requant_round_sat: SHIFT < 0 or OUT_I < 1");
   end

   logic signed [ACC_W:0] ext;
   assign ext = {acc[ACC_W-1], acc};

   if (SHIFT == 0) begin : g_noshift
      assign r = R_W'(ext);
   end else begin : g_shift
      localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
      logic signed [ACC_W:0] sum;
      // Sign-extended by one bit, so adding half an LSB cannot wrap.
      assign sum = ext + $signed(HALF);
      assign r = R_W'(sum >>> SHIFT);
   end

   logic ovf;
   assign ovf = r_q[R_W-1:W_OUT-1] != {(R_W-W_OUT+1){r_q[R_W-1]}};

   always_comb begin
      sat_data = r_q[W_OUT-1:0];
      sat = 1'b0;
      if (ovf) begin
         sat_data = r_q[R_W-1] ? MINV : MAXV;
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/acc_requant_pipe.sv
// Two-stage requantizer (round, then saturate) with valid/ready flow
// control and a sticky saturating count of clipped output samples.
module acc_requant_pipe
   import acc_requant_pipe_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int ACC_F = 16,
   parameter int W_OUT = acc_requant_pipe_pkg::W_OUT,
   parameter int OUT_I = acc_requant_pipe_pkg::OUT_I,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] out_data,
   output logic             out_sat,
   input  logic             sat_clear,
   output logic [CNT_W-1:0] sat_count
);

   localparam int SHIFT = calc_shift(ACC_F, W_OUT, OUT_I);
   localparam int R_W = ACC_W + 1 - SHIFT;

   if (SHIFT < 0 || OUT_I < 1) begin : g_bad_cfg
      $error("acc_requant_pipe: SHIFT < 0 or OUT_I < 1");
   end

   logic             s1_valid;
   logic [R_W-1:0]   r_d;
   logic [R_W-1:0]   r_q;
   logic [W_OUT-1:0] sat_data;
   logic             sat;
   logic             s1_en;
   logic             s2_en;

   assign s2_en = !out_valid || out_ready;
   assign s1_en = !s1_valid || s2_en;
   assign in_ready = s1_en;

   requant_round_sat #(
      .ACC_W (ACC_W),
      .ACC_F (ACC_F),
      .W_OUT (W_OUT),
      .OUT_I (OUT_I)
   ) u_round_sat (
      .acc      (in_data),
      .r        (r_d),
      .r_q      (r_q),
      .sat_data (sat_data),
      .sat      (sat)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         r_q      <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) r_q <= r_d;
      end
   end

   // Bubbles drop out_valid but keep the last data word.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= sat_data;
            out_sat  <= sat;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sat_count <= '0;
      end else if (sat_clear) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_acc_requant_pipe.sv
// Directed bench for acc_requant_pipe: rounding ties, clipping, backpressure,
// counter saturation/clear and asynchronous mid-stream reset.
module tb_acc_requant_pipe;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_data;
   logic        out_sat;
   logic        sat_clear = 1'b0;
   logic [15:0] sat_count;

   int checks = 0;
   int failures = 0;
   int sent;
   int got;

   localparam int NSAT = 65536 + 3;

   always #5 clock = ~clock;

   acc_requant_pipe dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_clear (sat_clear),
      .sat_count (sat_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_chk(input string tag, input logic [31:0] data,
                           input logic [31:0] exp_d, input logic exp_s,
                           input logic [31:0] exp_c);
      @(negedge clock);
      in_valid = 1'b1;
      in_data = data;
      out_ready = 1'b1;
      #1 chk({tag, "_in_ready"}, 32'(in_ready), 1);
      @(negedge clock);
      in_valid = 1'b0;
      #1 chk({tag, "_early"}, 32'(out_valid), 0);
      @(negedge clock);
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_data"}, 32'(out_data), exp_d);
      chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
      @(negedge clock);
      #1 chk({tag, "_count"}, 32'(sat_count), exp_c);
   endtask

   task automatic clr_same(input string tag);
      @(negedge clock);
      in_valid = 1'b1;
      in_data = 32'h0010_0000;
      out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      sat_clear = 1'b1;
      #1 chk({tag, "_sat"}, 32'(out_sat && out_valid), 1);
      @(negedge clock);
      sat_clear = 1'b0;
      #1 chk({tag, "_count"}, 32'(sat_count), 0);
   endtask

   initial begin
      repeat (2) @(negedge clock);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_sat", 32'(out_sat), 0);
      chk("rst_sat_count", 32'(sat_count), 0);
      resetn = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 1);

      send_chk("one_p5", 32'h0001_8000, 32'h180, 1'b0, 0);
      send_chk("tie_pos", 32'h0000_0080, 32'h001, 1'b0, 0);
      send_chk("tie_neg", 32'hFFFF_FF80, 32'h000, 1'b0, 0);
      send_chk("below_tie", 32'hFFFF_FF7F, 32'hFFF, 1'b0, 0);
      send_chk("sat_pos", 32'h0010_0000, 32'h7FF, 1'b1, 1);
      send_chk("sat_neg", 32'hFFF0_0000, 32'h800, 1'b1, 2);
      send_chk("min_exact", 32'hFFF8_0000, 32'h800, 1'b0, 2);
      send_chk("max_exact", 32'h0007_FF7F, 32'h7FF, 1'b0, 2);
      send_chk("max_round", 32'h0007_FF80, 32'h7FF, 1'b1, 3);

      // Ramp with a 5-cycle downstream stall at the start.
      sent = 0;
      got = 0;
      for (int c = 0; c < 60 && got < 8; c++) begin
         @(negedge clock);
         out_ready = (c >= 5);
         in_valid = (sent < 8);
         in_data = 32'h100 * (sent + 1);
         #1;
         if (c >= 2 && c < 5) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", 32'(out_data), 1);
         end
         if (c == 4) chk("bp_accepted", sent, 2);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            chk("bp_seq", 32'(out_data), got + 1);
            got++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_total", got, 8);
      @(negedge clock);
      #1 chk("bp_count", 32'(sat_count), 3);

      sat_clear = 1'b1;
      @(negedge clock);
      sat_clear = 1'b0;
      #1 chk("clear_idle", 32'(sat_count), 0);

      sent = 0;
      got = 0;
      for (int c = 0; c < 70000 && got < NSAT; c++) begin
         @(negedge clock);
         in_valid = (sent < NSAT);
         in_data = 32'h0010_0000;
         #1;
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) got++;
      end
      in_valid = 1'b0;
      chk("stream_total", got, NSAT);
      @(negedge clock);
      #1 chk("count_stick", 32'(sat_count), 32'hFFFF);

      clr_same("clr_full");
      send_chk("after_clr", 32'h0010_0000, 32'h7FF, 1'b1, 1);
      clr_same("clr_one");
      send_chk("pre_rst", 32'hFFF0_0000, 32'h800, 1'b1, 1);

      // Two samples held under stall, then asynchronous reset.
      @(negedge clock);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h0010_0000;
      @(negedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      #2 resetn = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_count", 32'(sat_count), 0);
      @(negedge clock);
      resetn = 1'b1;
      #1 chk("mrst_in_ready", 32'(in_ready), 1);
      send_chk("post_rst", 32'h0001_8000, 32'h180, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acc_requant_pipe.md
Name: acc_requant_pipe

Overview:
- Pipelined requantizer that sits directly upstream of the shift-based tanh PLA activation.
- Converts a wide signed accumulator value (MAC array output) into the signed fixed-point input format the activation expects.
- Applies round-half-up and saturation.
- Carries a valid/ready handshake with backpressure and a sticky, saturating overflow-event counter for accuracy monitoring.

Parameters:
- ACC_W, 32, accumulator wordlength (signed two's complement).
- ACC_F, 16, accumulator fractional bits.
- W_OUT, 12, output wordlength; equals the downstream activation's input wordlength.
- OUT_I, 4, output integer bits including sign; equals the activation's integer-bit count.
- CNT_W, 16, width of saturation-event counter.
- Derived: OUT_F = W_OUT-OUT_I; SHIFT = ACC_F-OUT_F. Elaboration must fail if SHIFT < 0 or OUT_I < 1.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  ACC_W  signed accumulator, Q(ACC_W-ACC_F).ACC_F.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  W_OUT  signed result, Q(OUT_I).OUT_F.
- out_sat  out  1  the current out_data was clipped.
- sat_clear  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_W  number of clipped samples transferred out; sticks at all-ones.

Behaviour:
- Reset is asynchronous and active-low; both clock and reset are single, as fixed above. On reset: all valid flags = 0, out_data = 0, out_sat = 0, sat_count = 0, in_ready = 1 after reset release.
- Transfers happen only on cycles where valid && ready. in_data is sampled only on an input transfer.
- Stage 1 (round):
  - r = (sign-extended in_data to ACC_W+1 bits) + 2^(SHIFT-1), then arithmetic right shift by SHIFT.
  - SHIFT = 0: no add, no shift.
  - Stage 1 registers r (ACC_W+1-SHIFT bits) and s1_valid.
- Stage 2 (saturate):
  - If r > 2^(W_OUT-1)-1: out_data = max, out_sat = 1.
  - If r < -2^(W_OUT-1): out_data = min, out_sat = 1.
  - Otherwise out_data = r[W_OUT-1:0], out_sat = 0.
  - Stage 2 registers out_data, out_sat and out_valid.
- Rounding is half-up, i.e. toward +inf on exact ties: -0.5 LSB -> 0, +0.5 LSB -> +1.
- Pipeline advance:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en; purely combinational from state and out_ready; no dependency on in_valid.
- Latency and capacity:
  - Latency is exactly 2 cycles from input transfer to out_valid when out_ready stays high.
  - Throughput is 1 sample/cycle.
  - Under stall the pipeline holds at most 2 samples.
  - No sample is dropped or duplicated.
  - out_data and out_sat stay stable while out_valid && !out_ready.
- Bubbles: when s2_en is high and s1_valid is 0, out_valid falls to 0 and out_data is retained (don't-care value).
- sat_count:
  - Increments on each output transfer (out_valid && out_ready) with out_sat = 1.
  - Holds at 2^CNT_W-1.
  - sat_clear has priority over a same-cycle increment: result is 0.
- Reset asserted mid-stream flushes both stages immediately, with no partial output. Samples in flight are lost by design.

Decomposition:
- Shared package holds:
  - the fixed-point format constants (W_OUT, OUT_I, OUT_F) so this block and the activation agree;
  - saturation bound constants;
  - the SHIFT derivation function.
- One sub-module is natural: requant_round_sat. It is the combinational round-plus-clip datapath, parameterized identically, and is instanced between the two pipeline registers so it can be unit-tested standalone.

Test Plan (defaults ACC_W=32, ACC_F=16, W_OUT=12, OUT_I=4):
- in_data=0x00018000 (1.5), out_ready=1 -> 2 cycles later out_data=0x180, out_sat=0, sat_count=0.
- Ties: in_data=0x00000080 -> 0x001; in_data=0xFFFFFF80 -> 0x000; in_data=0xFFFFFF7F -> 0xFFF.
- Saturation:
  - in_data=0x00100000 (+16.0) -> 0x7FF, out_sat=1, sat_count=1.
  - in_data=0xFFF00000 (-16.0) -> 0x800, out_sat=1, sat_count=2.
  - in_data=0xFFF80000 (-8.0) -> 0x800, out_sat=0, sat_count unchanged.
- Backpressure:
  - Drive a continuous ramp 0x100 steps and hold out_ready=0 for 5 cycles. in_ready must drop after 2 accepted samples and out_data must stay stable.
  - After release, the outputs must be the exact ramp sequence, in order, with no gap or duplicate.
- Counter: force 2^16+3 saturating samples -> sat_count=0xFFFF. Assert sat_clear in the same cycle as a saturating transfer -> sat_count=0.
- Reset mid-stream: with 2 samples held and out_ready=0, pulse resetn low -> out_valid=0, sat_count=0 immediately (asynchronous). After release, in_ready=1 and a new sample returns in 2 cycles.
